// File: rtl/cnn_pkg.sv
// Shared types and constants for the CNN layer sequencer.
// Provides the sequencer state enum and the layer index map.
package cnn_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT,
    RESULT,
    ERROR
  } seq_state_t;

  localparam int NUM_LAYERS = 5;

  localparam int L_CONV1 = 0;
  localparam int L_POOL1 = 1;
  localparam int L_CONV2 = 2;
  localparam int L_POOL2 = 3;
  localparam int L_DENSE = 4;

endpackage

// File: rtl/cnn_layer_sequencer_watchdog.sv
// Per-stage watchdog: counts enabled cycles since the last clear.
// Ports: clk, reset (async, high), clear, enable, expired.
module stage_watchdog #(
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] timer;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer <= '0;
    end else if (clear) begin
      timer <= '0;
    end else if (enable) begin
      timer <= timer + 1'b1;
    end
  end

  // Fires on the last permitted wait cycle; the FSM
  // leaves WAIT on it, so the timer never wraps.
  assign expired = enable && (timer == LIMIT);

endmodule

// File: rtl/cnn_layer_sequencer.sv
// Sequences the CNN layer engines for one frame with watchdog/abort.
// Ports: frame handshake, stage start/done, result handshake, status.
module cnn_layer_sequencer
  import cnn_pkg::*;
#(
  parameter int NUM_STAGES     = NUM_LAYERS,
  parameter int TIMEOUT_CYCLES = 20000,
  parameter int CNT_W          = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          frame_valid,
  output logic                          frame_ready,
  output logic [NUM_STAGES-1:0]         stage_start,
  input  logic [NUM_STAGES-1:0]         stage_done,
  output logic                          result_valid,
  input  logic                          result_ready,
  input  logic                          abort,
  output logic                          busy,
  output logic [$clog2(NUM_STAGES)-1:0] cur_stage,
  output logic                          error,
  output logic [$clog2(NUM_STAGES)-1:0] err_stage,
  output logic [CNT_W-1:0]              last_frame_cycles
);

  localparam int SW = $clog2(NUM_STAGES);
  localparam logic [SW-1:0] FIRST = SW'(L_CONV1);
  localparam logic [SW-1:0] LAST  = SW'(NUM_STAGES - 1);

  seq_state_t     state;
  logic [CNT_W-1:0] frame_cnt;
  logic [CNT_W-1:0] frame_inc;
  logic           done_cur;
  logic           wd_clear;
  logic           wd_en;
  logic           wd_expired;

  assign frame_inc = (frame_cnt == '1) ? frame_cnt
                                       : frame_cnt + 1'b1;

  assign done_cur = stage_done[cur_stage];

  assign wd_clear = abort || (state == START);
  assign wd_en    = !abort && (state == WAIT);

  stage_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wd (
    .clk    (clk),
    .reset  (reset),
    .clear  (wd_clear),
    .enable (wd_en),
    .expired(wd_expired)
  );

  assign frame_ready  = (state == IDLE);
  assign busy         = (state != IDLE);
  assign result_valid = (state == RESULT);

  // Abort cuts a start pulse in the same cycle so the
  // engine never launches on a frame being discarded.
  always_comb begin
    stage_start = '0;
    if (state == START && !abort) begin
      stage_start[cur_stage] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      cur_stage         <= FIRST;
      error             <= 1'b0;
      err_stage         <= '0;
      last_frame_cycles <= '0;
      frame_cnt         <= '0;
    end else if (abort) begin
      state     <= IDLE;
      cur_stage <= FIRST;
      error     <= 1'b0;
      err_stage <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (frame_valid) begin
            cur_stage <= FIRST;
            frame_cnt <= '0;
            state     <= START;
          end
        end
        START: begin
          frame_cnt <= frame_inc;
          state     <= WAIT;
        end
        WAIT: begin
          frame_cnt <= frame_inc;
          if (done_cur) begin
            if (cur_stage == LAST) begin
              last_frame_cycles <= frame_inc;
              state             <= RESULT;
            end else begin
              cur_stage <= cur_stage + 1'b1;
              state     <= START;
            end
          end else if (wd_expired) begin
            error     <= 1'b1;
            err_stage <= cur_stage;
            state     <= ERROR;
          end
        end
        RESULT: begin
          if (result_ready) begin
            state <= IDLE;
          end
        end
        ERROR: begin
          state <= ERROR;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Directed self-checking bench for cnn_layer_sequencer.
// Runs with NUM_STAGES=3, TIMEOUT_CYCLES=16.
module tb_cnn_layer_sequencer;

  logic        clk;
  logic        reset;
  logic        frame_valid;
  logic        frame_ready;
  logic [2:0]  stage_start;
  logic [2:0]  stage_done;
  logic        result_valid;
  logic        result_ready;
  logic        abort;
  logic        busy;
  logic [1:0]  cur_stage;
  logic        error;
  logic [1:0]  err_stage;
  logic [31:0] last_frame_cycles;

  int checks;
  int failures;

  cnn_layer_sequencer #(
    .NUM_STAGES    (3),
    .TIMEOUT_CYCLES(16),
    .CNT_W         (32)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .frame_valid      (frame_valid),
    .frame_ready      (frame_ready),
    .stage_start      (stage_start),
    .stage_done       (stage_done),
    .result_valid     (result_valid),
    .result_ready     (result_ready),
    .abort            (abort),
    .busy             (busy),
    .cur_stage        (cur_stage),
    .error            (error),
    .err_stage        (err_stage),
    .last_frame_cycles(last_frame_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    reset = 1'b1;
    #1;
    if (frame_ready !== 1'b1 || busy !== 1'b0 ||
        stage_start !== 3'b000 || result_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_ctl got fr=%b bz=%b st=%b rv=%b exp 1 0 000 0",
               frame_ready, busy, stage_start, result_valid);
    end
    checks++;
    if (cur_stage !== 2'd0 || error !== 1'b0 ||
        err_stage !== 2'd0 || last_frame_cycles !== 32'd0) begin
      failures++;
      $display("FAIL rst_stat got cs=%0d er=%b es=%0d lf=%0d exp 0 0 0 0",
               cur_stage, error, err_stage, last_frame_cycles);
    end
    checks++;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    if (frame_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_idle got fr=%b bz=%b exp 1 0",
               frame_ready, busy);
    end
    checks++;
  endtask

  task automatic test_nominal();
    logic [2:0] es;
    logic       erv;
    logic       efr;
    for (int c = 0; c <= 20; c++) begin
      frame_valid  = (c == 0);
      stage_done   = (c == 5)  ? 3'b001 :
                     (c == 10) ? 3'b010 :
                     (c == 15) ? 3'b100 : 3'b000;
      result_ready = (c == 18);
      #1;
      es  = (c == 1)  ? 3'b001 :
            (c == 6)  ? 3'b010 :
            (c == 11) ? 3'b100 : 3'b000;
      erv = (c >= 16 && c <= 18);
      efr = (c == 0 || c >= 19);
      if (stage_start !== es) begin
        failures++;
        $display("FAIL nom_start c=%0d got=%b exp=%b",
                 c, stage_start, es);
      end
      checks++;
      if (result_valid !== erv) begin
        failures++;
        $display("FAIL nom_rv c=%0d got=%b exp=%b",
                 c, result_valid, erv);
      end
      checks++;
      if (frame_ready !== efr) begin
        failures++;
        $display("FAIL nom_fr c=%0d got=%b exp=%b",
                 c, frame_ready, efr);
      end
      checks++;
      if (c == 16 && last_frame_cycles !== 32'd15) begin
        failures++;
        $display("FAIL nom_lat got=%0d exp=15",
                 last_frame_cycles);
      end
      if (c == 16) checks++;
      @(negedge clk);
    end
    frame_valid  = 1'b0;
    stage_done   = '0;
    result_ready = 1'b0;
  endtask

  task automatic test_spurious();
    logic [2:0] es;
    for (int c = 0; c <= 18; c++) begin
      frame_valid  = (c == 0);
      stage_done   = (c == 3)  ? 3'b100 :
                     (c == 5)  ? 3'b001 :
                     (c == 6)  ? 3'b010 :
                     (c == 10) ? 3'b010 :
                     (c == 15) ? 3'b100 : 3'b000;
      result_ready = (c == 16);
      #1;
      es = (c == 1)  ? 3'b001 :
           (c == 6)  ? 3'b010 :
           (c == 11) ? 3'b100 : 3'b000;
      if (stage_start !== es) begin
        failures++;
        $display("FAIL spur_start c=%0d got=%b exp=%b",
                 c, stage_start, es);
      end
      checks++;
      if (c == 4 && cur_stage !== 2'd0) begin
        failures++;
        $display("FAIL spur_cs got=%0d exp=0", cur_stage);
      end
      if (c == 4) checks++;
      if (c == 16 && (result_valid !== 1'b1 ||
                      last_frame_cycles !== 32'd15)) begin
        failures++;
        $display("FAIL spur_res got rv=%b lf=%0d exp 1 15",
                 result_valid, last_frame_cycles);
      end
      if (c == 16) checks++;
      @(negedge clk);
    end
    frame_valid  = 1'b0;
    stage_done   = '0;
    result_ready = 1'b0;
  endtask

  task automatic test_late_done();
    logic [2:0] es;
    for (int c = 0; c <= 30; c++) begin
      frame_valid  = (c == 0);
      stage_done   = (c == 5)  ? 3'b001 :
                     (c == 22) ? 3'b010 :
                     (c == 27) ? 3'b100 : 3'b000;
      result_ready = (c == 28);
      #1;
      es = (c == 1)  ? 3'b001 :
           (c == 6)  ? 3'b010 :
           (c == 23) ? 3'b100 : 3'b000;
      if (stage_start !== es) begin
        failures++;
        $display("FAIL late_start c=%0d got=%b exp=%b",
                 c, stage_start, es);
      end
      checks++;
      if (error !== 1'b0) begin
        failures++;
        $display("FAIL late_err c=%0d got=%b exp=0", c, error);
      end
      checks++;
      if (c == 28 && (result_valid !== 1'b1 ||
                      last_frame_cycles !== 32'd27)) begin
        failures++;
        $display("FAIL late_res got rv=%b lf=%0d exp 1 27",
                 result_valid, last_frame_cycles);
      end
      if (c == 28) checks++;
      if (c == 29 && frame_ready !== 1'b1) begin
        failures++;
        $display("FAIL late_idle got=%b exp=1", frame_ready);
      end
      if (c == 29) checks++;
      @(negedge clk);
    end
    frame_valid  = 1'b0;
    stage_done   = '0;
    result_ready = 1'b0;
  endtask

  task automatic test_watchdog();
    logic [2:0] es;
    logic       eer;
    logic       ebz;
    for (int c = 0; c <= 32; c++) begin
      frame_valid = (c == 0);
      stage_done  = (c == 5) ? 3'b001 : 3'b000;
      abort       = (c == 30);
      #1;
      es  = (c == 1) ? 3'b001 :
            (c == 6) ? 3'b010 : 3'b000;
      eer = (c >= 23 && c <= 30);
      ebz = (c >= 1 && c <= 30);
      if (stage_start !== es) begin
        failures++;
        $display("FAIL wd_start c=%0d got=%b exp=%b",
                 c, stage_start, es);
      end
      checks++;
      if (error !== eer) begin
        failures++;
        $display("FAIL wd_err c=%0d got=%b exp=%b", c, error, eer);
      end
      checks++;
      if (busy !== ebz || frame_ready !== !ebz) begin
        failures++;
        $display("FAIL wd_busy c=%0d got bz=%b fr=%b exp bz=%b",
                 c, busy, frame_ready, ebz);
      end
      checks++;
      if (c == 23 && err_stage !== 2'd1) begin
        failures++;
        $display("FAIL wd_es got=%0d exp=1", err_stage);
      end
      if (c == 23) checks++;
      if (c == 31 && (last_frame_cycles !== 32'd27 ||
                      cur_stage !== 2'd0 ||
                      err_stage !== 2'd0)) begin
        failures++;
        $display("FAIL wd_abort got lf=%0d cs=%0d es=%0d exp 27 0 0",
                 last_frame_cycles, cur_stage, err_stage);
      end
      if (c == 31) checks++;
      @(negedge clk);
    end
    frame_valid = 1'b0;
    stage_done  = '0;
    abort       = 1'b0;
  endtask

  task automatic test_abort_start();
    for (int c = 0; c <= 3; c++) begin
      frame_valid = (c == 0);
      abort       = (c == 1);
      #1;
      if (stage_start !== 3'b000) begin
        failures++;
        $display("FAIL ab_start c=%0d got=%b exp=000",
                 c, stage_start);
      end
      checks++;
      if (c >= 2 && (frame_ready !== 1'b1 || busy !== 1'b0)) begin
        failures++;
        $display("FAIL ab_idle c=%0d got fr=%b bz=%b exp 1 0",
                 c, frame_ready, busy);
      end
      if (c >= 2) checks++;
      @(negedge clk);
    end
    frame_valid = 1'b0;
    abort       = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [2:0] es;
    logic       erv;
    logic       efr;
    for (int c = 0; c <= 30; c++) begin
      frame_valid  = (c <= 29);
      stage_done   = (c == 5)  ? 3'b001 :
                     (c == 10) ? 3'b010 :
                     (c == 15) ? 3'b100 : 3'b000;
      result_ready = (c == 26);
      abort        = (c == 29);
      #1;
      es  = (c == 1)  ? 3'b001 :
            (c == 6)  ? 3'b010 :
            (c == 11) ? 3'b100 :
            (c == 28) ? 3'b001 : 3'b000;
      erv = (c >= 16 && c <= 26);
      efr = (c == 0 || c == 27 || c == 30);
      if (stage_start !== es) begin
        failures++;
        $display("FAIL b2b_start c=%0d got=%b exp=%b",
                 c, stage_start, es);
      end
      checks++;
      if (result_valid !== erv) begin
        failures++;
        $display("FAIL b2b_rv c=%0d got=%b exp=%b",
                 c, result_valid, erv);
      end
      checks++;
      if (frame_ready !== efr) begin
        failures++;
        $display("FAIL b2b_fr c=%0d got=%b exp=%b",
                 c, frame_ready, efr);
      end
      checks++;
      @(negedge clk);
    end
    frame_valid  = 1'b0;
    stage_done   = '0;
    result_ready = 1'b0;
    abort        = 1'b0;
  endtask

  task automatic test_async_reset();
    logic [2:0] es;
    for (int c = 0; c <= 13; c++) begin
      frame_valid = (c == 0);
      stage_done  = (c == 5)  ? 3'b001 :
                    (c == 10) ? 3'b010 : 3'b000;
      #1;
      es = (c == 1)  ? 3'b001 :
           (c == 6)  ? 3'b010 :
           (c == 11) ? 3'b100 : 3'b000;
      if (stage_start !== es) begin
        failures++;
        $display("FAIL ar_start c=%0d got=%b exp=%b",
                 c, stage_start, es);
      end
      checks++;
      if (c == 13 && cur_stage !== 2'd2) begin
        failures++;
        $display("FAIL ar_pre got cs=%0d exp=2", cur_stage);
      end
      if (c == 13) checks++;
      if (c < 13) @(negedge clk);
    end
    stage_done = '0;
    reset = 1'b1;
    #1;
    if (frame_ready !== 1'b1 || busy !== 1'b0 ||
        stage_start !== 3'b000 || cur_stage !== 2'd0 ||
        last_frame_cycles !== 32'd0 || error !== 1'b0) begin
      failures++;
      $display("FAIL ar_now got fr=%b bz=%b st=%b cs=%0d lf=%0d er=%b",
               frame_ready, busy, stage_start, cur_stage,
               last_frame_cycles, error);
    end
    checks++;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int c = 0; c <= 17; c++) begin
      frame_valid  = (c == 0);
      stage_done   = (c == 5)  ? 3'b001 :
                     (c == 10) ? 3'b010 :
                     (c == 15) ? 3'b100 : 3'b000;
      result_ready = (c == 16);
      #1;
      es = (c == 1)  ? 3'b001 :
           (c == 6)  ? 3'b010 :
           (c == 11) ? 3'b100 : 3'b000;
      if (stage_start !== es) begin
        failures++;
        $display("FAIL ar_run c=%0d got=%b exp=%b",
                 c, stage_start, es);
      end
      checks++;
      if (c == 16 && (result_valid !== 1'b1 ||
                      last_frame_cycles !== 32'd15)) begin
        failures++;
        $display("FAIL ar_res got rv=%b lf=%0d exp 1 15",
                 result_valid, last_frame_cycles);
      end
      if (c == 16) checks++;
      if (c == 17 && frame_ready !== 1'b1) begin
        failures++;
        $display("FAIL ar_idle got=%b exp=1", frame_ready);
      end
      if (c == 17) checks++;
      @(negedge clk);
    end
    frame_valid  = 1'b0;
    stage_done   = '0;
    result_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout bench did not finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    checks       = 0;
    failures     = 0;
    reset        = 1'b1;
    frame_valid  = 1'b0;
    stage_done   = '0;
    result_ready = 1'b0;
    abort        = 1'b0;
    @(negedge clk);
    test_reset();
    test_nominal();
    test_spurious();
    test_late_done();
    test_watchdog();
    test_abort_start();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
